// File: rtl/fetch_queue_multi.sv
// Multi-issue fetch queue: buffers variable-length fetch bundles with their metadata and
// hands up to numDecoders entries per cycle, in program order, to whichever decoders are ready.
module fetch_queue_multi #(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int instructionsPerBundle   = 4,
    parameter int numDecoders             = 4,
    parameter int queueIndexBits          = 4,
    parameter int PidSize                 = 32,
    parameter int TidSize                 = 64,
    parameter int instructionCounterWidth = 64,
    parameter int fetchQueueInstance      = 0,
    localparam int LenW = (instructionsPerBundle > 1) ? $clog2(instructionsPerBundle) : 1
) (
    input  logic                                           clock_i,
    input  logic                                           reset_i,
    input  logic                                           flush_i,
    input  logic                                           bundleWrite_i,
    input  logic [addressWidth-1:0]                        bundleAddress_i,
    input  logic [LenW-1:0]                                bundleLen_i,
    input  logic [PidSize-1:0]                             bundlePid_i,
    input  logic [TidSize-1:0]                             bundleTid_i,
    input  logic [instructionCounterWidth-1:0]             bundleStartMajId_i,
    input  logic [instructionsPerBundle*instructionWidth-1:0] bundle_i,
    output logic                                           bundleAccept_o,
    input  logic [numDecoders-1:0]                         decodeAvailable_i,
    output logic [numDecoders-1:0]                         decoderEn_o,
    output logic [numDecoders*instructionWidth-1:0]        decoderIns_o,
    output logic [numDecoders*addressWidth-1:0]            decoderAddress_o,
    output logic [numDecoders*instructionCounterWidth-1:0] decoderMajId_o,
    output logic [numDecoders*PidSize-1:0]                 decoderPid_o,
    output logic [numDecoders*TidSize-1:0]                 decoderTid_o,
    output logic [queueIndexBits-1:0]                      front_o,
    output logic [queueIndexBits-1:0]                      back_o,
    output logic [queueIndexBits:0]                        count_o,
    output logic                                           isFull_o,
    output logic                                           isEmpty_o,
    output logic                                           dropped_o
);

    localparam int QB    = queueIndexBits;
    localparam int Depth = 2 ** queueIndexBits;
    localparam int N     = instructionsPerBundle;
    localparam int D     = numDecoders;
    localparam int IW    = instructionWidth;
    localparam int AW    = addressWidth;
    localparam int CW    = instructionCounterWidth;

    // The queue must hold at least one full bundle and one full issue group.
    if (fetchQueueInstance < 0 || Depth < N || Depth < D) begin : g_param_check
        $error("fetch_queue_multi: invalid parameter set");
    end

    logic [IW-1:0]      ins_mem   [Depth];
    logic [AW-1:0]      addr_mem  [Depth];
    logic [CW-1:0]      maj_mem   [Depth];
    logic [PidSize-1:0] pid_mem   [Depth];
    logic [TidSize-1:0] tid_mem   [Depth];

    logic [QB-1:0]      front_q, front_d;
    logic [QB-1:0]      back_q, back_d;
    logic [QB:0]        count_q, count_d;
    logic               dropped_q, dropped_d;
    logic [D-1:0]       en_q, en_d;
    logic [D*IW-1:0]    ins_q, ins_d;
    logic [D*AW-1:0]    addr_q, addr_d;
    logic [D*CW-1:0]    maj_q, maj_d;
    logic [D*PidSize-1:0] pid_q, pid_d;
    logic [D*TidSize-1:0] tid_q, tid_d;

    logic [LenW:0]      wr_len;
    logic [QB:0]        free_slots;
    logic               wr_accept;
    logic [N-1:0]       slot_we;
    logic [QB-1:0]      slot_idx [N];
    logic [QB:0]        issue_cnt;
    logic [QB-1:0]      rd_idx;

    always_comb begin
        wr_len     = {1'b0, bundleLen_i} + (LenW+1)'(1);
        free_slots = (QB+1)'(Depth) - count_q;
        wr_accept  = bundleWrite_i && !flush_i && (free_slots >= (QB+1)'(wr_len));
        for (int i = 0; i < N; i++) begin
            slot_we[i]  = wr_accept && ((LenW+1)'(i) < wr_len);
            slot_idx[i] = back_q + QB'(i);
        end
    end

    assign bundleAccept_o = free_slots >= (QB+1)'(N);

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clock_i) begin
        for (int i = 0; i < N; i++) begin
            if (slot_we[i]) begin
                ins_mem[slot_idx[i]]  <= bundle_i[(N-1-i)*IW +: IW];
                addr_mem[slot_idx[i]] <= bundleAddress_i + AW'(4*i);
                maj_mem[slot_idx[i]]  <= bundleStartMajId_i + CW'(i);
                pid_mem[slot_idx[i]]  <= bundlePid_i;
                tid_mem[slot_idx[i]]  <= bundleTid_i;
            end
        end
    end

    // Ready decoders are filled lowest index first, each taking the next entry in order.
    always_comb begin
        issue_cnt = '0;
        rd_idx    = '0;
        en_d      = '0;
        ins_d     = '0;
        addr_d    = '0;
        maj_d     = '0;
        pid_d     = '0;
        tid_d     = '0;
        for (int d = 0; d < D; d++) begin
            rd_idx = front_q + issue_cnt[QB-1:0];
            if (decodeAvailable_i[d] && (issue_cnt < count_q)) begin
                en_d[d]                      = 1'b1;
                ins_d[d*IW +: IW]            = ins_mem[rd_idx];
                addr_d[d*AW +: AW]           = addr_mem[rd_idx];
                maj_d[d*CW +: CW]            = maj_mem[rd_idx];
                pid_d[d*PidSize +: PidSize]  = pid_mem[rd_idx];
                tid_d[d*TidSize +: TidSize]  = tid_mem[rd_idx];
                issue_cnt                    = issue_cnt + (QB+1)'(1);
            end
        end

        front_d   = front_q + issue_cnt[QB-1:0];
        back_d    = wr_accept ? (back_q + QB'(wr_len)) : back_q;
        count_d   = count_q + (wr_accept ? (QB+1)'(wr_len) : '0) - issue_cnt;
        dropped_d = bundleWrite_i && !flush_i && !wr_accept;

        if (flush_i) begin
            en_d    = '0;
            ins_d   = '0;
            addr_d  = '0;
            maj_d   = '0;
            pid_d   = '0;
            tid_d   = '0;
            front_d = '0;
            back_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            front_q   <= '0;
            back_q    <= '0;
            count_q   <= '0;
            dropped_q <= 1'b0;
            en_q      <= '0;
            ins_q     <= '0;
            addr_q    <= '0;
            maj_q     <= '0;
            pid_q     <= '0;
            tid_q     <= '0;
        end else begin
            front_q   <= front_d;
            back_q    <= back_d;
            count_q   <= count_d;
            dropped_q <= dropped_d;
            en_q      <= en_d;
            ins_q     <= ins_d;
            addr_q    <= addr_d;
            maj_q     <= maj_d;
            pid_q     <= pid_d;
            tid_q     <= tid_d;
        end
    end

    assign front_o          = front_q;
    assign back_o           = back_q;
    assign count_o          = count_q;
    assign isFull_o         = count_q == (QB+1)'(Depth);
    assign isEmpty_o        = count_q == '0;
    assign dropped_o        = dropped_q;
    assign decoderEn_o      = en_q;
    assign decoderIns_o     = ins_q;
    assign decoderAddress_o = addr_q;
    assign decoderMajId_o   = maj_q;
    assign decoderPid_o     = pid_q;
    assign decoderTid_o     = tid_q;

endmodule
